// File: rtl/wb_latency_mem.sv
// wb_latency_mem: Wishbone B4 pipelined memory. Each request answers LATENCY cycles after accept (ack, or err if out of range).
// Backpressure: wb_stall_o while MAX_OUT requests are outstanding; WB_LATENCY_MEM_STALL_INJECT_EN adds a periodic stall.
module wb_latency_mem #(
    parameter int AW           = 12,
    parameter int DEPTH_WORDS  = 1024,
    parameter int LATENCY      = 2,
    parameter int MAX_OUT      = 2,
    parameter int STALL_PERIOD = 4
) (
    input  logic          cpu_clock_i,
    input  logic          rst_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    output logic          wb_stall_o,
    output logic          wb_ack_o,
    output logic [31:0]   wb_dat_o,
    output logic          wb_err_o
);
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic        vld;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic [31:0]   mem [DEPTH_WORDS];
    rsp_t          pipe [LATENCY];
    rsp_t          rsp_in;
    logic [CW-1:0] outcnt;
    logic [IW-1:0] idx;
    logic          in_range;
    logic          accept;
    logic          emit;
    logic          inj_stall;

`ifdef WB_LATENCY_MEM_STALL_INJECT_EN
    localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    logic [SW-1:0] stall_cnt;

    always_ff @(posedge cpu_clock_i) begin
        if (rst_i || !wb_cyc_i) begin
            stall_cnt <= '0;
        end else if (stall_cnt == SW'(STALL_PERIOD - 1)) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + SW'(1);
        end
    end

    assign inj_stall = (stall_cnt == SW'(STALL_PERIOD - 1));
`else
    assign inj_stall = 1'b0;
`endif

    assign idx        = wb_adr_i[IW-1:0];
    assign in_range   = (32'(wb_adr_i) < 32'(DEPTH_WORDS));
    // Deliberately no look-ahead at a response retiring this cycle.
    assign wb_stall_o = wb_cyc_i & ((outcnt == CW'(MAX_OUT)) | inj_stall);
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    // Dropping cyc kills a response even in the cycle it would have appeared.
    assign emit       = pipe[LATENCY-1].vld & wb_cyc_i;

    always_comb begin
        rsp_in = '0;
        if (accept) begin
            rsp_in.vld = 1'b1;
            rsp_in.err = ~in_range;
            if (in_range && !wb_we_i) begin
                rsp_in.rdata = mem[idx];
            end
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (accept && wb_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    mem[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (rst_i || !wb_cyc_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
            outcnt <= '0;
        end else begin
            pipe[0] <= rsp_in;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
            outcnt <= outcnt + CW'(accept) - CW'(emit);
        end
    end

    assign wb_ack_o = emit & ~pipe[LATENCY-1].err;
    assign wb_err_o = emit &  pipe[LATENCY-1].err;
    assign wb_dat_o = wb_ack_o ? pipe[LATENCY-1].rdata : 32'h0;

endmodule

// File: tb/tb_wb_latency_mem.sv
// Directed bench for wb_latency_mem: cycle-by-cycle vector table plus hand-written reset/stall sequences.
module tb_wb_latency_mem;
    logic        cpu_clock_i = 1'b0;
    logic        rst_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [11:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stall_o;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        wb_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 cpu_clock_i = ~cpu_clock_i;

    wb_latency_mem dut (
        .cpu_clock_i (cpu_clock_i),
        .rst_i       (rst_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_we_i     (wb_we_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_sel_i    (wb_sel_i),
        .wb_stall_o  (wb_stall_o),
        .wb_ack_o    (wb_ack_o),
        .wb_dat_o    (wb_dat_o),
        .wb_err_o    (wb_err_o)
    );

    // One record per clock cycle: bus inputs for that cycle and the expected {stall, ack, err, dat}.
    typedef struct {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [11:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [34:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                                input logic [2:0] f, input logic [31:0] rd);
        vec_t v;
        v.cyc = 1'b1; v.stb = 1'b1; v.we = 1'b1; v.adr = a; v.dat = d; v.sel = s;
        v.exp = {f, rd};
        return v;
    endfunction

    function automatic vec_t rdv(input logic [11:0] a, input logic [2:0] f, input logic [31:0] rd);
        vec_t v;
        v.cyc = 1'b1; v.stb = 1'b1; v.we = 1'b0; v.adr = a; v.dat = 32'h0; v.sel = 4'hF;
        v.exp = {f, rd};
        return v;
    endfunction

    function automatic vec_t idle(input logic c, input logic [2:0] f, input logic [31:0] rd);
        vec_t v;
        v.cyc = c; v.stb = 1'b0; v.we = 1'b0; v.adr = 12'h0; v.dat = 32'h0; v.sel = 4'h0;
        v.exp = {f, rd};
        return v;
    endfunction

    task automatic check(input string name, input logic [34:0] want);
        logic [34:0] got;
        got = {wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: stall/ack/err/dat got %b/%b/%b/%h, expected %b/%b/%b/%h",
                     name, got[34], got[33], got[32], got[31:0],
                     want[34], want[33], want[32], want[31:0]);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic apply(input vec_t v);
        @(posedge cpu_clock_i);
        #1;
        wb_cyc_i = v.cyc;
        wb_stb_i = v.stb;
        wb_we_i  = v.we;
        wb_adr_i = v.adr;
        wb_dat_i = v.dat;
        wb_sel_i = v.sel;
        @(negedge cpu_clock_i);
    endtask

    initial begin
        rst_i    = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        repeat (3) @(posedge cpu_clock_i);
        #1 rst_i = 1'b0;
        @(negedge cpu_clock_i);
        check("reset_state", 35'h0);

`ifndef WB_LATENCY_MEM_STALL_INJECT_EN
        // full-word write then read of addr 5
        vecs.push_back(idle(1'b0, 3'b000, 32'h0));
        vecs.push_back(wr(12'd5, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0));
        vecs.push_back(idle(1'b1, 3'b000, 32'h0));
        vecs.push_back(idle(1'b1, 3'b010, 32'h0));
        vecs.push_back(rdv(12'd5, 3'b000, 32'h0));
        vecs.push_back(idle(1'b1, 3'b000, 32'h0));
        vecs.push_back(idle(1'b1, 3'b010, 32'hDEADBEEF));
        // single-lane write, read-after-write back to back
        vecs.push_back(wr(12'd5, 32'h0000AA00, 4'b0010, 3'b000, 32'h0));
        vecs.push_back(rdv(12'd5, 3'b000, 32'h0));
        vecs.push_back(idle(1'b1, 3'b110, 32'h0));
        vecs.push_back(idle(1'b1, 3'b010, 32'hDEADAAEF));
        // three writes with stb held: stall at the third cycle
        vecs.push_back(wr(12'd0, 32'hA0A0A0A0, 4'hF, 3'b000, 32'h0));
        vecs.push_back(wr(12'd1, 32'hB1B1B1B1, 4'hF, 3'b000, 32'h0));
        vecs.push_back(wr(12'd2, 32'hC2C2C2C2, 4'hF, 3'b110, 32'h0));
        vecs.push_back(wr(12'd2, 32'hC2C2C2C2, 4'hF, 3'b010, 32'h0));
        vecs.push_back(idle(1'b1, 3'b000, 32'h0));
        vecs.push_back(idle(1'b1, 3'b010, 32'h0));
        // three reads with stb held: accepts t, t+1, t+3; acks t+2, t+3, t+5
        vecs.push_back(rdv(12'd0, 3'b000, 32'h0));
        vecs.push_back(rdv(12'd1, 3'b000, 32'h0));
        vecs.push_back(rdv(12'd2, 3'b110, 32'hA0A0A0A0));
        vecs.push_back(rdv(12'd2, 3'b010, 32'hB1B1B1B1));
        vecs.push_back(idle(1'b1, 3'b000, 32'h0));
        vecs.push_back(idle(1'b1, 3'b010, 32'hC2C2C2C2));
        // out of range write and read error; addr 0 must not alias 1024
        vecs.push_back(wr(12'd1024, 32'hFFFFFFFF, 4'hF, 3'b000, 32'h0));
        vecs.push_back(rdv(12'd1024, 3'b000, 32'h0));
        vecs.push_back(idle(1'b1, 3'b101, 32'h0));
        vecs.push_back(idle(1'b1, 3'b001, 32'h0));
        vecs.push_back(rdv(12'd0, 3'b000, 32'h0));
        vecs.push_back(idle(1'b1, 3'b000, 32'h0));
        vecs.push_back(idle(1'b1, 3'b010, 32'hA0A0A0A0));
        // last implemented word
        vecs.push_back(wr(12'd1023, 32'h55AA55AA, 4'hF, 3'b000, 32'h0));
        vecs.push_back(rdv(12'd1023, 3'b000, 32'h0));
        vecs.push_back(idle(1'b1, 3'b110, 32'h0));
        vecs.push_back(idle(1'b1, 3'b010, 32'h55AA55AA));
        // abort after write: no ack, write persists, outcnt restarts at 0
        vecs.push_back(wr(12'd7, 32'h12345678, 4'hF, 3'b000, 32'h0));
        vecs.push_back(idle(1'b0, 3'b000, 32'h0));
        vecs.push_back(idle(1'b1, 3'b000, 32'h0));
        vecs.push_back(rdv(12'd7, 3'b000, 32'h0));
        vecs.push_back(rdv(12'd7, 3'b000, 32'h0));
        vecs.push_back(idle(1'b1, 3'b110, 32'h12345678));
        vecs.push_back(idle(1'b1, 3'b010, 32'h12345678));
        // abort in the very cycle the ack is due
        vecs.push_back(rdv(12'd5, 3'b000, 32'h0));
        vecs.push_back(idle(1'b1, 3'b000, 32'h0));
        vecs.push_back(idle(1'b0, 3'b000, 32'h0));
        vecs.push_back(idle(1'b1, 3'b000, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // reset with two reads in flight
        apply(rdv(12'd0, 3'b000, 32'h0));
        check("rst_req0", 35'h0);
        apply(rdv(12'd1, 3'b000, 32'h0));
        check("rst_req1", 35'h0);
        @(posedge cpu_clock_i);
        #1;
        rst_i    = 1'b1;
        wb_stb_i = 1'b0;
        @(posedge cpu_clock_i);
        #1 rst_i = 1'b0;
        @(negedge cpu_clock_i);
        check("rst_after1", 35'h0);
        apply(idle(1'b1, 3'b000, 32'h0));
        check("rst_after2", 35'h0);
        apply(rdv(12'd2, 3'b000, 32'h0));
        check("rst_new0", 35'h0);
        apply(rdv(12'd0, 3'b000, 32'h0));
        check("rst_new1", 35'h0);
        apply(idle(1'b1, 3'b000, 32'h0));
        check("rst_new_ack0", {3'b110, 32'hC2C2C2C2});
        apply(idle(1'b1, 3'b000, 32'h0));
        check("rst_new_ack1", {3'b010, 32'hA0A0A0A0});
`else
        // injected stall every 4th cycle of an open bus cycle
        apply(idle(1'b0, 3'b000, 32'h0));
        check("inj_idle", 35'h0);
        for (int i = 0; i < 9; i++) begin
            apply(idle(1'b1, 3'b000, 32'h0));
            check($sformatf("inj_cyc%0d", i), {((i % 4) == 3), 2'b00, 32'h0});
        end
        apply(idle(1'b0, 3'b000, 32'h0));
        check("inj_drop", 35'h0);
        apply(idle(1'b1, 3'b000, 32'h0));
        check("inj_restart", 35'h0);
        // reset with two requests in flight
        apply(wr(12'd3, 32'h01020304, 4'hF, 3'b000, 32'h0));
        check("inj_rst_req0", 35'h0);
        apply(rdv(12'd3, 3'b000, 32'h0));
        check("inj_rst_req1", 35'h0);
        @(posedge cpu_clock_i);
        #1;
        rst_i    = 1'b1;
        wb_stb_i = 1'b0;
        @(posedge cpu_clock_i);
        #1 rst_i = 1'b0;
        @(negedge cpu_clock_i);
        check("inj_rst_after1", 35'h0);
        apply(idle(1'b1, 3'b000, 32'h0));
        check("inj_rst_after2", 35'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
